// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
//   start, flush     : request and synchronous abort
//   funct3           : M-extension operation select
//   rs1_data/rs2_data: operands from the register file read ports
//   rd_addr          : destination register index
//   busy             : unit is occupied (stalls the pipeline)
//   done             : one-cycle result strobe (register file write enable)
//   result, rd_out   : register file write data / write address
interface muldiv_if;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, flush, funct3, rs1_data, rs2_data, rd_addr,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data, rd_addr,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : muldiv_if.slave (start/flush/funct3/operands/rd_addr in,
//                busy/done/result/rd_out out)
// Multiply is a 32-step shift-add on operand magnitudes, divide is a 32-step
// restoring division; a FIX cycle applies sign correction. Divide by zero and
// signed overflow skip straight to DONE.
module muldiv_unit (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // mul: {product_hi, multiplier/product_lo}; div: {remainder, dividend/quotient}
  logic [63:0] acc_q, acc_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;

  // Datapath helpers
  logic        sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [31:0] in_mag_a, in_mag_b;
  logic        div_zero, div_ovf;
  logic [31:0] fast_val;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic [63:0] mul_step, div_step;
  logic [63:0] prod;
  logic [31:0] quo, rem, fix_val;

  always_comb begin
    sgn_a    = !(bus.funct3 == 3'b011 || bus.funct3 == 3'b101 || bus.funct3 == 3'b111);
    sgn_b    = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001 ||
                bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
    in_neg_a = sgn_a & bus.rs1_data[31];
    in_neg_b = sgn_b & bus.rs2_data[31];
    in_mag_a = in_neg_a ? -bus.rs1_data : bus.rs1_data;
    in_mag_b = in_neg_b ? -bus.rs2_data : bus.rs2_data;

    div_zero = bus.funct3[2] && (bus.rs2_data == 32'd0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);
    if (div_zero) begin
      fast_val = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
    end else begin
      fast_val = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    mul_step = {mul_sum, acc_q[31:1]};

    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (!div_diff[32]) begin
      div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_step = {div_shift[31:0], acc_q[30:0], 1'b0};
    end

    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo  = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
    rem  = neg_a_q ? -acc_q[63:32] : acc_q[63:32];
    if (funct3_q[2]) begin
      fix_val = funct3_q[1] ? rem : quo;
    end else begin
      fix_val = (funct3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          funct3_d = bus.funct3;
          rd_d     = bus.rd_addr;
          mag_a_d  = in_mag_a;
          mag_b_d  = in_mag_b;
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          cnt_d    = 6'd0;
          acc_d    = bus.funct3[2] ? {32'd0, in_mag_a} : {32'd0, in_mag_b};
          if (div_zero || div_ovf) begin
            result_d = fast_val;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = funct3_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = StFix;
        end
      end
      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_val;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      funct3_q <= 3'd0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule
